// File: rtl/rx_block_buffer_if.sv
// rx_block_buffer_if: receive-side bus between the UART receiver / AES consumer
// and rx_block_buffer.
//   rx_byte, rx_done       byte strobe from the UART receiver
//   read_en, overflow_clr  consumer pop and sticky-flag clear
//   block_out              FIFO head block (valid while empty=0)
//   empty, full, level     FIFO occupancy
//   overflow, frame_err    sticky drop flag, partial-block timeout pulse
// Modports: master drives the inputs (UART/consumer side), slave is the buffer.
interface rx_block_buffer_if #(
  parameter int unsigned BYTE_W      = 8,
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned DEPTH       = 4
);
  localparam int unsigned BLK_W = BYTE_W * BLOCK_BYTES;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [BYTE_W-1:0] rx_byte;
  logic              rx_done;
  logic              read_en;
  logic              overflow_clr;
  logic [BLK_W-1:0]  block_out;
  logic              empty;
  logic              full;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              frame_err;

  modport master (
    output rx_byte, rx_done, read_en, overflow_clr,
    input  block_out, empty, full, level, overflow, frame_err
  );

  modport slave (
    input  rx_byte, rx_done, read_en, overflow_clr,
    output block_out, empty, full, level, overflow, frame_err
  );
endinterface

// File: rtl/rx_block_buffer.sv
// rx_block_buffer: packs BLOCK_BYTES received bytes into one block and queues
// completed blocks in a DEPTH-entry first-word-fall-through FIFO.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    rx_block_buffer_if.slave (rx_byte/rx_done in, read_en/overflow_clr in,
//          block_out/empty/full/level/overflow/frame_err out)
// Optional feature: define RX_TIMEOUT_EN to discard a partial block after
// TIMEOUT_CYCLES idle cycles (frame_err pulses); otherwise frame_err is 0.
// block_out is the combinational FWFT view of the head RAM entry.
module rx_block_buffer #(
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned BLOCK_BYTES    = 16,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned MSB_FIRST      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic              clk,
  input logic              reset,
  rx_block_buffer_if.slave bus
);
  localparam int unsigned BLK_W = BYTE_W * BLOCK_BYTES;
  localparam int unsigned CNT_W = $clog2(BLOCK_BYTES);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned LAST  = BLOCK_BYTES - 1;

  // Reject parameterisations the pointer/counter arithmetic cannot handle.
  if (BLOCK_BYTES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("rx_block_buffer: invalid parameterisation");
  end

  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [BLK_W-1:0] asm_q, asm_d;
  logic [BLK_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, do_push, drop;
  logic             timeout;

  // Assembly: drop the incoming byte into its slot of the block.
  always_comb begin
    asm_d = asm_q;
    if (bus.rx_done) begin
      for (int k = 0; k < int'(BLOCK_BYTES); k++) begin
        if (byte_cnt_q == CNT_W'(k)) begin
          if (MSB_FIRST != 0) begin
            asm_d[(int'(BLOCK_BYTES) - 1 - k) * int'(BYTE_W) +: BYTE_W] = bus.rx_byte;
          end else begin
            asm_d[k * int'(BYTE_W) +: BYTE_W] = bus.rx_byte;
          end
        end
      end
    end
  end

  // FIFO control: a push to a full FIFO survives only if the head pops on the same edge.
  always_comb begin
    push       = bus.rx_done && (byte_cnt_q == CNT_W'(LAST));
    pop        = bus.read_en && !empty_q;
    do_push    = push && (!full_q || pop);
    drop       = push && full_q && !pop;

    byte_cnt_d = byte_cnt_q;
    if (bus.rx_done) begin
      byte_cnt_d = push ? '0 : byte_cnt_q + CNT_W'(1);
    end else if (timeout) begin
      byte_cnt_d = '0;
    end

    wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
    rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    empty_d    = (wr_ptr_d == rd_ptr_d);
    full_d     = (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]) &&
                 (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]);
    level_d    = LVL_W'(wr_ptr_d - rd_ptr_d);

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Assembly, pointer and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Block storage; cleared on reset so block_out reads 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= asm_d;
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);

  logic [IDLE_W-1:0] idle_q;
  logic              frame_err_q;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = !bus.rx_done && (byte_cnt_q != '0) &&
                   (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Idle counter runs only while a partial block is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= timeout;
      if (bus.rx_done || timeout || byte_cnt_q == '0) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + IDLE_W'(1);
      end
    end
  end

  assign bus.frame_err = frame_err_q;
`else
  assign timeout       = 1'b0;
  assign bus.frame_err = 1'b0;
`endif

  assign bus.block_out = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
endmodule
